// File: rtl/mem_stage_ctrl.sv
// Memory-access pipeline stage: DEPTH-word data memory with byte/half/word
// loads and stores, configurable latency and a stall output. Optional macro: MEM_STAGE_ALIGN_EXC_EN.
module mem_stage_ctrl #(
    parameter int WORD_LEN = 32,
    parameter int DEPTH    = 256,
    parameter int LATENCY  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                mem_read_en,
    input  logic                mem_write_en,
    input  logic [1:0]          size,
    input  logic                load_unsigned,
    input  logic [WORD_LEN-1:0] addr,
    input  logic [WORD_LEN-1:0] store_value,
    output logic [WORD_LEN-1:0] load_data,
    output logic                resp_valid,
    output logic                stall
`ifdef MEM_STAGE_ALIGN_EXC_EN
    ,
    output logic                misalign
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic [2:0]          cnt;
    logic [WORD_LEN-1:0] mem [DEPTH];

    logic                cap_write;
    logic [1:0]          cap_size;
    logic                cap_unsigned;
    logic [AW+1:0]       cap_addr;
    logic [WORD_LEN-1:0] cap_store;

    logic                accept;
    logic                do_access;
    logic                use_cap;
    logic                acc_write;
    logic [1:0]          acc_size;
    logic                acc_unsigned;
    logic [AW+1:0]       acc_addr;
    logic [WORD_LEN-1:0] acc_store;
    logic                acc_mis;
    logic                is_half;
    logic                is_word;
    logic [1:0]          lane;
    logic [AW-1:0]       idx;
    logic [WORD_LEN-1:0] rd_word;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic [WORD_LEN-1:0] rd_ext;
    logic [3:0]          be;
    logic [WORD_LEN-1:0] wdata;
    logic [WORD_LEN-1:0] wr_word;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^addr[WORD_LEN-1:AW+2];

    // The DONE cycle doubles as an accept cycle, so only BUSY blocks new requests.
    always_comb begin
        accept    = req_valid && (mem_read_en || mem_write_en) && (state != BUSY);
        stall     = rst && (accept || (state == BUSY));
        do_access = (LATENCY == 1) ? accept : ((state == BUSY) && (cnt == 3'd1));
    end

    always_comb begin
        use_cap      = (state == BUSY);
        acc_write    = use_cap ? cap_write    : mem_write_en;
        acc_size     = use_cap ? cap_size     : size;
        acc_unsigned = use_cap ? cap_unsigned : load_unsigned;
        acc_addr     = use_cap ? cap_addr     : addr[AW+1:0];
        acc_store    = use_cap ? cap_store    : store_value;
        is_half      = (acc_size == 2'b01);
        is_word      = acc_size[1];
        idx          = acc_addr[AW+1:2];
`ifdef MEM_STAGE_ALIGN_EXC_EN
        acc_mis = (is_half && acc_addr[0]) || (is_word && (acc_addr[1:0] != 2'b00));
        lane    = acc_addr[1:0];
`else
        acc_mis = 1'b0;
        lane    = is_word ? 2'b00 : (is_half ? {acc_addr[1], 1'b0} : acc_addr[1:0]);
`endif
    end

    always_comb begin
        rd_word = mem[idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = rd_word[{lane[1], 4'b0000} +: 16];
        if (is_word)
            rd_ext = rd_word;
        else if (is_half)
            rd_ext = {{(WORD_LEN-16){~acc_unsigned & rd_half[15]}}, rd_half};
        else
            rd_ext = {{(WORD_LEN-8){~acc_unsigned & rd_byte[7]}}, rd_byte};
    end

    // Replicate the store data across lanes; the byte enables pick the lanes to update.
    always_comb begin
        if (is_word) begin
            be    = 4'b1111;
            wdata = acc_store;
        end else if (is_half) begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{acc_store[15:0]}};
        end else begin
            be    = 4'b0001 << lane;
            wdata = {4{acc_store[7:0]}};
        end
        wr_word = rd_word;
        for (int unsigned k = 0; k < 4; k++) begin
            if (be[k])
                wr_word[8*k +: 8] = wdata[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            load_data    <= '0;
            resp_valid   <= 1'b0;
            cap_write    <= 1'b0;
            cap_size     <= '0;
            cap_unsigned <= 1'b0;
            cap_addr     <= '0;
            cap_store    <= '0;
`ifdef MEM_STAGE_ALIGN_EXC_EN
            misalign     <= 1'b0;
`endif
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            resp_valid <= do_access;
`ifdef MEM_STAGE_ALIGN_EXC_EN
            misalign   <= do_access && acc_mis;
`endif
            if (do_access) begin
                if (acc_write) begin
                    if (!acc_mis)
                        mem[idx] <= wr_word;
                end else begin
                    load_data <= acc_mis ? '0 : rd_ext;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        cap_write    <= mem_write_en;
                        cap_size     <= size;
                        cap_unsigned <= load_unsigned;
                        cap_addr     <= addr[AW+1:0];
                        cap_store    <= store_value;
                        if (LATENCY == 1) begin
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                            cnt   <= 3'(LATENCY - 1);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt == 3'd1) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: LATENCY=1 vector table plus LATENCY=3 back-to-back and reset sequences.
module tb_mem_stage_ctrl;

`ifdef MEM_STAGE_ALIGN_EXC_EN
    localparam bit AE = 1'b1;
`else
    localparam bit AE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req1 = 1'b0;
    logic        req3 = 1'b0;
    logic        mem_read_en = 1'b0;
    logic        mem_write_en = 1'b0;
    logic [1:0]  size = 2'b10;
    logic        load_unsigned = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] store_value = '0;
    logic [31:0] load_data1, load_data3;
    logic        resp_valid1, resp_valid3, stall1, stall3;
    logic        mis1, mis3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.WORD_LEN(32), .DEPTH(256), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req1), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .size(size), .load_unsigned(load_unsigned),
        .addr(addr), .store_value(store_value), .load_data(load_data1),
        .resp_valid(resp_valid1), .stall(stall1)
`ifdef MEM_STAGE_ALIGN_EXC_EN
        , .misalign(mis1)
`endif
    );

    mem_stage_ctrl #(.WORD_LEN(32), .DEPTH(256), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req3), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .size(size), .load_unsigned(load_unsigned),
        .addr(addr), .store_value(store_value), .load_data(load_data3),
        .resp_valid(resp_valid3), .stall(stall3)
`ifdef MEM_STAGE_ALIGN_EXC_EN
        , .misalign(mis3)
`endif
    );

`ifndef MEM_STAGE_ALIGN_EXC_EN
    assign mis1 = 1'b0;
    assign mis3 = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic        re;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] sv;
        logic [31:0] exp_load;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic we, input logic re, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] sv,
                        input logic [31:0] exp_load, input logic exp_mis);
        vecs[i].we = we; vecs[i].re = re; vecs[i].sz = sz; vecs[i].uns = uns;
        vecs[i].a = a; vecs[i].sv = sv; vecs[i].exp_load = exp_load; vecs[i].exp_mis = exp_mis;
    endtask

    task automatic drive(input logic we, input logic re, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] sv);
        mem_write_en = we; mem_read_en = re; size = sz; load_unsigned = uns;
        addr = a; store_value = sv;
    endtask

    task automatic acc1(input int i);
        @(negedge clk);
        drive(vecs[i].we, vecs[i].re, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].sv);
        req1 = 1'b1;
        #1 chk($sformatf("v%0d_stall_accept", i), 32'(stall1), 32'd1);
        @(posedge clk);
        #1 req1 = 1'b0;
        #1;
        chk($sformatf("v%0d_resp", i), 32'(resp_valid1), 32'd1);
        chk($sformatf("v%0d_load", i), load_data1, vecs[i].exp_load);
        chk($sformatf("v%0d_stall_done", i), 32'(stall1), 32'd0);
        if (AE) chk($sformatf("v%0d_misalign", i), 32'(mis1), 32'(vecs[i].exp_mis));
    endtask

    task automatic rd3(input string name, input logic [31:0] a, input logic [31:0] exp);
        int lat;
        lat = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b10, 1'b0, a, 32'h0);
        req3 = 1'b1;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(posedge clk);
            #1;
            if (resp_valid3) lat = c;
        end
        req3 = 1'b0;
        chk({name, "_latency"}, 32'(lat), 32'd3);
        chk({name, "_data"}, load_data3, exp);
    endtask

    initial begin
        setv(0,  1, 0, 2'b10, 0, 32'h10,  32'h8badf00d, 32'h0, 0);
        setv(1,  0, 1, 2'b10, 0, 32'h10,  32'h0, 32'h8badf00d, 0);
        setv(2,  1, 0, 2'b10, 0, 32'h10,  32'h0, 32'h8badf00d, 0);
        setv(3,  1, 0, 2'b00, 0, 32'h13,  32'haaaaaa80, 32'h8badf00d, 0);
        setv(4,  0, 1, 2'b00, 0, 32'h13,  32'h0, 32'hffffff80, 0);
        setv(5,  0, 1, 2'b00, 1, 32'h13,  32'h0, 32'h00000080, 0);
        setv(6,  0, 1, 2'b10, 0, 32'h10,  32'h0, 32'h80000000, 0);
        setv(7,  1, 0, 2'b10, 0, 32'h400, 32'hcafebabe, 32'h80000000, 0);
        setv(8,  0, 1, 2'b10, 0, 32'h0,   32'h0, 32'hcafebabe, 0);
        setv(9,  1, 0, 2'b10, 0, 32'h20,  32'h0, 32'hcafebabe, 0);
        setv(10, 1, 0, 2'b01, 0, 32'h21,  32'hffff1234, 32'hcafebabe, AE);
        setv(11, 0, 1, 2'b10, 0, 32'h20,  32'h0, AE ? 32'h0 : 32'h00001234, 0);
        setv(12, 1, 0, 2'b01, 0, 32'h22,  32'h00008001, AE ? 32'h0 : 32'h00001234, 0);
        setv(13, 0, 1, 2'b01, 0, 32'h22,  32'h0, 32'hffff8001, 0);
        setv(14, 0, 1, 2'b01, 1, 32'h22,  32'h0, 32'h00008001, 0);
        setv(15, 0, 1, 2'b10, 0, 32'h20,  32'h0, AE ? 32'h80010000 : 32'h80011234, 0);
        setv(16, 1, 0, 2'b11, 0, 32'h30,  32'h11223344, AE ? 32'h80010000 : 32'h80011234, 0);
        setv(17, 0, 1, 2'b00, 1, 32'h31,  32'h0, 32'h00000033, 0);
        setv(18, 0, 1, 2'b01, 1, 32'h32,  32'h0, 32'h00001122, 0);
        setv(19, 0, 1, 2'b10, 0, 32'h31,  32'h0, AE ? 32'h0 : 32'h11223344, AE);
        setv(20, 1, 1, 2'b10, 0, 32'h34,  32'h00000055, AE ? 32'h0 : 32'h11223344, 0);
        setv(21, 0, 1, 2'b10, 0, 32'h34,  32'h0, 32'h00000055, 0);
        setv(22, 0, 1, 2'b00, 0, 32'h30,  32'h0, 32'h00000044, 0);

        #1;
        chk("rst_load1", load_data1, 32'h0);
        chk("rst_resp1", 32'(resp_valid1), 32'd0);
        chk("rst_stall1", 32'(stall1), 32'd0);
        chk("rst_stall3", 32'(stall3), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 23; i++) acc1(i);

        // Request with neither enable must not be accepted.
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        req1 = 1'b1;
        #1 chk("noen_stall", 32'(stall1), 32'd0);
        @(posedge clk);
        #1 chk("noen_resp", 32'(resp_valid1), 32'd0);
        req1 = 1'b0;

        // LATENCY=3: store then back-to-back load of the same word.
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'hdeadbeef);
        req3 = 1'b1;
        #1 chk("l3_stall_c0", 32'(stall3), 32'd1);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 3) begin
                chk("l3_store_resp", 32'(resp_valid3), 32'd1);
                chk("l3_store_load_kept", load_data3, 32'h0);
                mem_write_en = 1'b0;
                mem_read_en = 1'b1;
            end else if (c == 6) begin
                chk("l3_load_resp", 32'(resp_valid3), 32'd1);
                chk("l3_load_data", load_data3, 32'hdeadbeef);
                req3 = 1'b0;
            end else begin
                chk($sformatf("l3_resp_c%0d", c), 32'(resp_valid3), 32'd0);
            end
            #1 chk($sformatf("l3_stall_c%0d", c), 32'(stall3), (c < 6) ? 32'd1 : 32'd0);
        end

        // Asynchronous reset while a store is in flight.
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h50, 32'h12345678);
        req3 = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_load3", load_data3, 32'h0);
        chk("arst_resp3", 32'(resp_valid3), 32'd0);
        chk("arst_stall3", 32'(stall3), 32'd0);
        chk("arst_load1", load_data1, 32'h0);
        if (AE) chk("arst_mis3", 32'(mis3), 32'd0);
        req3 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rd3("arst_rd50", 32'h50, 32'h0);
        rd3("arst_rd40", 32'h40, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Parametrised memory-access stage for the pipelined CPU, the successor to the single-cycle MEM stage. It owns a DEPTH-word data memory with byte/half/word loads and stores, sign/zero extension, and a configurable access latency. A stall output holds the pipeline while an access is in flight. It sits between the EX/MEM and MEM/WB pipeline registers; the ALU result is the byte address.

## Interface
- WORD_LEN, 32: data and address width; must be 32.
- DEPTH, 256: memory depth in words; must be a power of two, 2 or more.
- LATENCY, 1: cycles from accept to response; legal range 1..4.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  an access is presented this cycle.
- mem_read_en  in  1  load request.
- mem_write_en  in  1  store request; wins over mem_read_en if both are high.
- size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- load_unsigned  in  1  zero-extend byte/half loads; 0 means sign-extend.
- addr  in  WORD_LEN  byte address (ALU result).
- store_value  in  WORD_LEN  store data, right-aligned.
- load_data  out  WORD_LEN  extended load result.
- resp_valid  out  1  one-cycle pulse when an access completes.
- stall  out  1  the pipeline must freeze and hold its inputs stable.
- misalign  out  1  misaligned access; this port exists only with the macro.

## Operation
- FSM states:
  - IDLE: a request is accepted when req_valid is high and (mem_read_en or mem_write_en) is high. Operands are captured into registers. Go to BUSY with cnt=LATENCY-1, or to DONE directly if LATENCY=1.
  - BUSY: inputs are ignored. cnt decrements; at cnt=1, go to DONE.
  - DONE: resp_valid=1. Return to IDLE, and accept a new request in this same cycle (back-to-back).
- Word index is addr[log2(DEPTH)+1:2]. Higher address bits are ignored, so the address wraps modulo DEPTH words.
- Byte lanes are little-endian; byte lane k occupies bits 8k+7:8k.
- Store, byte: store_value[7:0] is written to lane addr[1:0].
- Store, half: store_value[15:0] is written to lanes {addr[1],0} and {addr[1],1}.
- Store, word: all lanes are written. Other lanes are unchanged.
- Load: the selected byte or half is shifted to bit 0, then zero- or sign-extended per load_unsigned. A word load returns the word as stored.
- Stores commit on the clock edge that enters DONE. load_data keeps its previous value on a store response.
- Requests with neither enable high are never accepted; stall stays 0.

## Timing
- Reset (rst=0, asynchronous) sets the following, regardless of FSM state:
  - FSM to IDLE; cnt=0.
  - load_data=0, resp_valid=0, stall=0, misalign=0.
  - All memory words to 0.
  - Any in-flight store is dropped.
- For a request accepted at cycle t:
  - resp_valid and load_data are valid in cycle t+LATENCY.
  - stall is high in cycles t..t+LATENCY-1. It is combinational in cycle t: (IDLE and accept).
  - With LATENCY=1, stall is high only in cycle t.
- A store responding at t+LATENCY is visible to a load accepted in that same cycle. The response cycle doubles as the next accept cycle.
- Throughput is one access per LATENCY cycles.
- load_data and resp_valid are registered outputs.

## Configuration
- MEM_STAGE_ALIGN_EXC_EN defined:
  - Misaligned means a half with addr[0]=1, or a word with addr[1:0]≠0.
  - Such an access completes with normal latency.
  - misalign=1 for that access's response cycle only; it is low otherwise.
  - A misaligned store writes nothing. A misaligned load returns load_data=0.
- MEM_STAGE_ALIGN_EXC_EN undefined:
  - The misalign port is absent.
  - Half accesses force addr[0]=0; word accesses force addr[1:0]=0. The access then proceeds aligned.

## Test plan
- Reset, then with LATENCY=1: word store 0x8badf00d to addr 0x10, then a word load of 0x10. Required: load_data=0x8badf00d one cycle after the load accept; stall high for exactly 1 cycle per access.
- Byte store 0x80 to addr 0x13 over a zeroed word. Required: a signed byte load of 0x13 returns 0xFFFFFF80; an unsigned byte load returns 0x00000080; a word load of 0x10 returns 0x80000000.
- LATENCY=3: store followed immediately by a load to the same address. Required: stall high for 3 cycles per access; the load response shows the new data; resp_valid pulses at t+3 and t+6.
- DEPTH=256: word store to addr 0x400. Required: a word load of addr 0x0 returns the stored value (wrap-around).
- Half store of 0x1234 to addr 0x21. With the macro: misalign=1 and memory unchanged. Without the macro: the lower half of word 0x20 reads 0x1234.
- Assert rst=0 mid-BUSY on a pending store. Required: all outputs 0 immediately; a later load of that address returns 0.
